// File: rtl/arm_rf_pkg.sv
// Shared types and helpers for the LDM/STM register-file sequencer.
package arm_rf_pkg;

  localparam int REG_NUM_W = 5;
  localparam int NUM_REGS  = 16;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_WB,
    ST_DONE
  } state_t;

  // Addressing mode as {P, U}.
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } addr_mode_t;

  function automatic logic [31:0] span_bytes(input logic [REG_NUM_W-1:0] n);
    return {25'd0, n, 2'b00};
  endfunction

  // Lowest address touched; the walk always ascends from here.
  function automatic logic [31:0] start_addr(input addr_mode_t mode,
                                             input logic [31:0] base,
                                             input logic [REG_NUM_W-1:0] n);
    case (mode)
      MODE_IA: return base;
      MODE_IB: return base + WORD_BYTES;
      MODE_DA: return base - span_bytes(n) + WORD_BYTES;
      default: return base - span_bytes(n);
    endcase
  endfunction

  function automatic logic [31:0] final_base(input logic up,
                                             input logic [31:0] base,
                                             input logic [REG_NUM_W-1:0] n);
    return up ? (base + span_bytes(n)) : (base - span_bytes(n));
  endfunction

endpackage

// File: rtl/reg_list_scan.sv
// Combinational register-list scanner: lowest set index, any-set flag and popcount.
module reg_list_scan
  import arm_rf_pkg::*;
(
  input  logic [NUM_REGS-1:0]  list,
  output logic [3:0]           lowest,
  output logic                 any_set,
  output logic [REG_NUM_W-1:0] count
);

  always_comb begin
    lowest  = '0;
    count   = '0;
    any_set = |list;
    // Descending scan so the last hit is the lowest set bit.
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (list[i]) lowest = 4'(i);
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      count = count + {4'd0, list[i]};
    end
  end

endmodule

// File: rtl/block_xfer_seq.sv
// LDM/STM sequencer: walks the register list in ascending order, one memory word
// per handshake, then optionally writes the updated base back to the register file.
module block_xfer_seq
  import arm_rf_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_load,
  input  logic [15:0]          reg_list,
  input  logic [3:0]           base_reg,
  input  logic [31:0]          base_addr,
  input  logic                 up,
  input  logic                 pre,
  input  logic                 wback,
  output logic [REG_NUM_W-1:0] rf_read_num,
  input  logic [31:0]          rf_read_data,
  output logic [REG_NUM_W-1:0] rf_write_num,
  output logic [31:0]          rf_write_data,
  output logic                 rf_regwrite,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata,
  output logic                 busy,
  output logic                 done
);

  state_t state, state_nxt;

  logic        is_load_r;
  logic        wback_r;
  logic        skip_wb_r;
  logic [3:0]  base_reg_r;
  logic [15:0] list_r;
  logic [31:0] addr_r;
  logic [31:0] final_r;

  logic [15:0]          scan_list;
  logic [3:0]           cur;
  logic                 scan_any;
  logic [REG_NUM_W-1:0] scan_count;
  logic [15:0]          list_clr;

  // In IDLE the scanner sizes the incoming list; afterwards it walks the latched one.
  assign scan_list = (state == ST_IDLE) ? reg_list : list_r;

  reg_list_scan u_scan (
    .list    (scan_list),
    .lowest  (cur),
    .any_set (scan_any),
    .count   (scan_count)
  );

  assign list_clr = list_r & ~(16'd1 << cur);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (state == ST_IDLE && start) begin
      is_load_r  <= is_load;
      wback_r    <= wback;
      base_reg_r <= base_reg;
      list_r     <= reg_list;
      skip_wb_r  <= is_load & reg_list[base_reg];
      addr_r     <= start_addr(addr_mode_t'({pre, up}), base_addr, scan_count);
      final_r    <= final_base(up, base_addr, scan_count);
    end else if (state == ST_XFER && mem_ack) begin
      list_r <= list_clr;
      addr_r <= addr_r + WORD_BYTES;
    end
  end

  always_comb begin
    state_nxt     = state;
    rf_read_num   = '0;
    rf_write_num  = '0;
    rf_write_data = '0;
    rf_regwrite   = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    busy          = 1'b0;
    done          = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) state_nxt = scan_any ? ST_XFER : ST_DONE;
      end
      ST_XFER: begin
        busy        = 1'b1;
        mem_req     = 1'b1;
        mem_we      = ~is_load_r;
        mem_addr    = addr_r;
        rf_read_num = {1'b0, cur};
        mem_wdata   = is_load_r ? 32'd0 : rf_read_data;
        if (mem_ack) begin
          if (is_load_r) begin
            rf_regwrite   = 1'b1;
            rf_write_num  = {1'b0, cur};
            rf_write_data = mem_rdata;
          end
          // A loaded base register keeps the loaded value, so no writeback then.
          if (list_clr == 16'd0) state_nxt = (wback_r && !skip_wb_r) ? ST_WB : ST_DONE;
        end
      end
      ST_WB: begin
        busy          = 1'b1;
        rf_regwrite   = 1'b1;
        rf_write_num  = {1'b0, base_reg_r};
        rf_write_data = final_r;
        state_nxt     = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // An acknowledge landing in the reset cycle must not reach the register file.
    if (reset) rf_regwrite = 1'b0;
  end

endmodule

// File: tb/tb_block_xfer_seq.sv
// Self-checking bench for block_xfer_seq: directed scenarios plus randomized runs
// against a list-walking reference model.
module tb_block_xfer_seq;

  logic        clock = 1'b0;
  logic        reset, start, is_load, up, pre, wback, mem_ack;
  logic [15:0] reg_list;
  logic [3:0]  base_reg;
  logic [31:0] base_addr, rf_read_data, rf_write_data, mem_addr, mem_wdata, mem_rdata;
  logic [4:0]  rf_read_num, rf_write_num;
  logic        rf_regwrite, mem_req, mem_we, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rf [16];
  logic [31:0] rf_snap [16];
  logic        rf_init;
  logic [15:0] rf_seed;
  logic        force_en;
  logic [31:0] force_val;

  logic [31:0] ob_addr[$], ob_wdata[$], ob_rdata[$], wr_data[$];
  logic        ob_we[$];
  logic [4:0]  ob_rnum[$], wr_num[$];
  int          wr_cyc[$];
  int          done_cyc, last_ack_cyc, first_req_cyc, req_cyc_cnt, unstable_cnt;
  logic        timed_out;

  logic [31:0] exp_addr[$];
  int          exp_reg[$];
  logic [31:0] exp_final;
  logic        exp_wb;

  always #5 clock = ~clock;

  block_xfer_seq dut (
    .clock(clock), .reset(reset), .start(start), .is_load(is_load),
    .reg_list(reg_list), .base_reg(base_reg), .base_addr(base_addr),
    .up(up), .pre(pre), .wback(wback),
    .rf_read_num(rf_read_num), .rf_read_data(rf_read_data),
    .rf_write_num(rf_write_num), .rf_write_data(rf_write_data), .rf_regwrite(rf_regwrite),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done)
  );

  assign rf_read_data = rf[rf_read_num[3:0]];

  always @(posedge clock) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) rf[i] <= {rf_seed, 12'h0, 4'(i)};
    end else if (rf_regwrite) begin
      rf[rf_write_num[3:0]] <= rf_write_data;
    end
  end

  // Reference: registers go to consecutive ascending words from the lowest address.
  function automatic void build_model(input logic ld, input logic [15:0] lst, input logic [3:0] br,
                                      input logic [31:0] base, input logic u, input logic p,
                                      input logic w);
    int n;
    logic [31:0] lo;
    n = $countones(lst);
    if (u) lo = p ? base + 32'd4 : base;
    else   lo = p ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4;
    exp_addr.delete();
    exp_reg.delete();
    for (int r = 0; r < 16; r++) begin
      if (lst[r]) begin
        exp_addr.push_back(lo + 32'(4 * exp_reg.size()));
        exp_reg.push_back(r);
      end
    end
    exp_final = u ? base + 32'(4 * n) : base - 32'(4 * n);
    exp_wb    = w && (n > 0) && !(ld && lst[br]);
  endfunction

  // Issues one start, plays the memory side, and records what the DUT did.
  task automatic run_xfer(input logic ld, input logic [15:0] lst, input logic [3:0] br,
                          input logic [31:0] base, input logic u, input logic p, input logic w,
                          input int smin, input int smax);
    int stall;
    logic pend, p_we;
    logic [31:0] p_addr;
    logic [4:0] p_rnum;
    ob_addr.delete(); ob_we.delete(); ob_wdata.delete(); ob_rnum.delete(); ob_rdata.delete();
    wr_num.delete(); wr_data.delete(); wr_cyc.delete();
    done_cyc = -1; last_ack_cyc = -1; first_req_cyc = -1; req_cyc_cnt = 0; unstable_cnt = 0;
    pend = 1'b0; p_we = 1'b0; p_addr = '0; p_rnum = '0;
    for (int i = 0; i < 16; i++) rf_snap[i] = rf[i];
    is_load = ld; reg_list = lst; base_reg = br; base_addr = base;
    up = u; pre = p; wback = w; start = 1'b1;
    @(negedge clock);
    is_load = 1'($urandom); reg_list = 16'($urandom); base_reg = 4'($urandom);
    base_addr = $urandom; up = 1'($urandom); pre = 1'($urandom); wback = 1'($urandom);
    stall = $urandom_range(smax, smin);
    for (int cyc = 0; cyc < 300 && done_cyc < 0; cyc++) begin
      start = 1'($urandom);
      mem_ack = 1'b0;
      mem_rdata = force_en ? force_val : $urandom;
      if (mem_req) begin
        if (stall == 0) mem_ack = 1'b1;
        else stall--;
      end
      #1;
      if (mem_req) begin
        req_cyc_cnt++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
        if (pend && (mem_addr !== p_addr || mem_we !== p_we || rf_read_num !== p_rnum))
          unstable_cnt++;
        pend = !mem_ack; p_addr = mem_addr; p_we = mem_we; p_rnum = rf_read_num;
        if (mem_ack) begin
          ob_addr.push_back(mem_addr); ob_we.push_back(mem_we); ob_wdata.push_back(mem_wdata);
          ob_rnum.push_back(rf_read_num); ob_rdata.push_back(mem_rdata);
          last_ack_cyc = cyc;
          stall = $urandom_range(smax, smin);
        end
      end else begin
        pend = 1'b0;
      end
      if (rf_regwrite) begin
        wr_num.push_back(rf_write_num); wr_data.push_back(rf_write_data); wr_cyc.push_back(cyc);
      end
      if (done) done_cyc = cyc;
      @(negedge clock);
    end
    start = 1'b0;
    mem_ack = 1'b0;
    timed_out = (done_cyc < 0);
  endtask

  task automatic test_reset();
    reset = 1'b1; rf_init = 1'b1; rf_seed = 16'($urandom); start = 1'b0; is_load = 1'b0;
    reg_list = '0; base_reg = '0; base_addr = '0; up = 1'b0; pre = 1'b0; wback = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; force_en = 1'b0; force_val = '0;
    repeat (3) @(negedge clock);
    rf_init = 1'b0; reset = 1'b0; mem_ack = 1'b1;
    #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b want 0", mem_req); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 32'd0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 32'd0) $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); else n_pass++;
    n_checks++; if (rf_read_num !== 5'd0) $display("FAIL reset_rf_read_num got %0d want 0", rf_read_num); else n_pass++;
    n_checks++; if (rf_write_num !== 5'd0) $display("FAIL reset_rf_write_num got %0d want 0", rf_write_num); else n_pass++;
    n_checks++; if (rf_write_data !== 32'd0) $display("FAIL reset_rf_write_data got %h want 0", rf_write_data); else n_pass++;
    n_checks++; if (rf_regwrite !== 1'b0) $display("FAIL reset_rf_regwrite got %b want 0", rf_regwrite); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    @(negedge clock);
    mem_ack = 1'b0;
  endtask

  task automatic test_ldmia();
    run_xfer(1'b1, 16'h0005, 4'd9, 32'h100, 1'b1, 1'b0, 1'b0, 0, 0);
    n_checks++; if (timed_out) $display("FAIL ldmia_done got none want pulse"); else n_pass++;
    n_checks++; if (first_req_cyc !== 0) $display("FAIL ldmia_req_latency got %0d want 0", first_req_cyc); else n_pass++;
    n_checks++; if (ob_addr.size() !== 2) $display("FAIL ldmia_words got %0d want 2", ob_addr.size()); else n_pass++;
    n_checks++; if (wr_num.size() !== 2) $display("FAIL ldmia_writes got %0d want 2", wr_num.size()); else n_pass++;
    if (ob_addr.size() == 2 && wr_num.size() == 2) begin
      n_checks++; if (ob_addr[0] !== 32'h100) $display("FAIL ldmia_addr0 got %h want 100", ob_addr[0]); else n_pass++;
      n_checks++; if (ob_addr[1] !== 32'h104) $display("FAIL ldmia_addr1 got %h want 104", ob_addr[1]); else n_pass++;
      n_checks++; if (ob_we[0] !== 1'b0) $display("FAIL ldmia_we got %b want 0", ob_we[0]); else n_pass++;
      n_checks++; if (wr_num[0] !== 5'd0 || wr_data[0] !== ob_rdata[0])
        $display("FAIL ldmia_wr0 got r%0d=%h want r0=%h", wr_num[0], wr_data[0], ob_rdata[0]); else n_pass++;
      n_checks++; if (wr_num[1] !== 5'd2 || wr_data[1] !== ob_rdata[1])
        $display("FAIL ldmia_wr1 got r%0d=%h want r2=%h", wr_num[1], wr_data[1], ob_rdata[1]); else n_pass++;
      n_checks++; if (rf[2] !== ob_rdata[1]) $display("FAIL ldmia_r2 got %h want %h", rf[2], ob_rdata[1]); else n_pass++;
    end
    n_checks++; if (last_ack_cyc !== 1) $display("FAIL ldmia_b2b got %0d want 1", last_ack_cyc); else n_pass++;
    n_checks++; if (done_cyc !== 2) $display("FAIL ldmia_done_cyc got %0d want 2", done_cyc); else n_pass++;
  endtask

  task automatic test_stmdb_wb();
    run_xfer(1'b0, 16'h4006, 4'd13, 32'h200, 1'b0, 1'b1, 1'b1, 0, 0);
    n_checks++; if (timed_out) $display("FAIL stmdb_done got none want pulse"); else n_pass++;
    n_checks++; if (ob_addr.size() !== 3) $display("FAIL stmdb_words got %0d want 3", ob_addr.size()); else n_pass++;
    if (ob_addr.size() == 3) begin
      n_checks++; if (ob_addr[0] !== 32'h1F4 || ob_wdata[0] !== rf_snap[1])
        $display("FAIL stmdb_w0 got %h:%h want 1f4:%h", ob_addr[0], ob_wdata[0], rf_snap[1]); else n_pass++;
      n_checks++; if (ob_addr[1] !== 32'h1F8 || ob_wdata[1] !== rf_snap[2])
        $display("FAIL stmdb_w1 got %h:%h want 1f8:%h", ob_addr[1], ob_wdata[1], rf_snap[2]); else n_pass++;
      n_checks++; if (ob_addr[2] !== 32'h1FC || ob_wdata[2] !== rf_snap[14])
        $display("FAIL stmdb_w2 got %h:%h want 1fc:%h", ob_addr[2], ob_wdata[2], rf_snap[14]); else n_pass++;
      n_checks++; if (ob_we[2] !== 1'b1) $display("FAIL stmdb_we got %b want 1", ob_we[2]); else n_pass++;
    end
    n_checks++; if (wr_num.size() !== 1) $display("FAIL stmdb_writes got %0d want 1", wr_num.size()); else n_pass++;
    if (wr_num.size() == 1) begin
      n_checks++; if (wr_num[0] !== 5'd13 || wr_data[0] !== 32'h1F4)
        $display("FAIL stmdb_wb got r%0d=%h want r13=1f4", wr_num[0], wr_data[0]); else n_pass++;
    end
    n_checks++; if (done_cyc !== last_ack_cyc + 2)
      $display("FAIL stmdb_done_cyc got %0d want %0d", done_cyc, last_ack_cyc + 2); else n_pass++;
  endtask

  task automatic test_ldmib_stall();
    run_xfer(1'b1, 16'h0001, 4'd5, 32'h40, 1'b1, 1'b1, 1'b0, 3, 3);
    n_checks++; if (timed_out) $display("FAIL ldmib_done got none want pulse"); else n_pass++;
    n_checks++; if (req_cyc_cnt !== 4) $display("FAIL ldmib_req_cycles got %0d want 4", req_cyc_cnt); else n_pass++;
    n_checks++; if (unstable_cnt !== 0) $display("FAIL ldmib_stable got %0d changes want 0", unstable_cnt); else n_pass++;
    n_checks++; if (ob_addr.size() !== 1) $display("FAIL ldmib_words got %0d want 1", ob_addr.size()); else n_pass++;
    n_checks++; if (wr_num.size() !== 1) $display("FAIL ldmib_writes got %0d want 1", wr_num.size()); else n_pass++;
    if (ob_addr.size() == 1 && wr_num.size() == 1) begin
      n_checks++; if (ob_addr[0] !== 32'h44) $display("FAIL ldmib_addr got %h want 44", ob_addr[0]); else n_pass++;
      n_checks++; if (wr_cyc[0] !== 3) $display("FAIL ldmib_wr_cycle got %0d want 3", wr_cyc[0]); else n_pass++;
      n_checks++; if (wr_num[0] !== 5'd0 || wr_data[0] !== ob_rdata[0])
        $display("FAIL ldmib_wr got r%0d=%h want r0=%h", wr_num[0], wr_data[0], ob_rdata[0]); else n_pass++;
    end
  endtask

  task automatic test_empty();
    run_xfer(1'b1, 16'h0000, 4'd2, 32'h80, 1'b1, 1'b0, 1'b1, 0, 0);
    n_checks++; if (done_cyc !== 0) $display("FAIL empty_done_cyc got %0d want 0", done_cyc); else n_pass++;
    n_checks++; if (req_cyc_cnt !== 0) $display("FAIL empty_mem_req got %0d cycles want 0", req_cyc_cnt); else n_pass++;
    n_checks++; if (wr_num.size() !== 0) $display("FAIL empty_writes got %0d want 0", wr_num.size()); else n_pass++;
    #1;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL empty_after got done=%b busy=%b want 0 0", done, busy); else n_pass++;
  endtask

  task automatic test_base_in_list();
    force_en = 1'b1; force_val = 32'hDEAD;
    run_xfer(1'b1, 16'h0008, 4'd3, 32'h600, 1'b1, 1'b0, 1'b1, 0, 1);
    force_en = 1'b0;
    n_checks++; if (timed_out) $display("FAIL bil_done got none want pulse"); else n_pass++;
    n_checks++; if (wr_num.size() !== 1) $display("FAIL bil_writes got %0d want 1", wr_num.size()); else n_pass++;
    if (wr_num.size() == 1) begin
      n_checks++; if (wr_num[0] !== 5'd3 || wr_data[0] !== 32'hDEAD)
        $display("FAIL bil_wr got r%0d=%h want r3=dead", wr_num[0], wr_data[0]); else n_pass++;
    end
    n_checks++; if (rf[3] !== 32'hDEAD) $display("FAIL bil_r3 got %h want dead", rf[3]); else n_pass++;
    n_checks++; if (done_cyc !== last_ack_cyc + 1)
      $display("FAIL bil_done_cyc got %0d want %0d", done_cyc, last_ack_cyc + 1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r1_before;
    int stray;
    r1_before = rf[1];
    is_load = 1'b1; reg_list = 16'h000F; base_reg = 4'd9; base_addr = 32'h300;
    up = 1'b1; pre = 1'b0; wback = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_0000;
    #1;
    n_checks++; if (mem_req !== 1'b1 || rf_regwrite !== 1'b1 || rf_write_num !== 5'd0)
      $display("FAIL rmid_first got req=%b we=%b r%0d want 1 1 r0", mem_req, rf_regwrite, rf_write_num); else n_pass++;
    @(negedge clock);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h2222_0000;
    #1;
    n_checks++; if (rf_regwrite !== 1'b0) $display("FAIL rmid_ack_in_reset got %b want 0", rf_regwrite); else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rmid_idle got req=%b busy=%b done=%b want 0 0 0", mem_req, busy, done); else n_pass++;
    n_checks++; if (mem_addr !== 32'd0 || rf_read_num !== 5'd0 || rf_write_num !== 5'd0)
      $display("FAIL rmid_outs got addr=%h rn=%0d wn=%0d want 0", mem_addr, rf_read_num, rf_write_num); else n_pass++;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      if (rf_regwrite) stray++;
    end
    mem_ack = 1'b0;
    n_checks++; if (stray !== 0) $display("FAIL rmid_stray_writes got %0d want 0", stray); else n_pass++;
    n_checks++; if (rf[1] !== r1_before) $display("FAIL rmid_r1 got %h want %h", rf[1], r1_before); else n_pass++;
    run_xfer(1'b1, 16'h00F0, 4'd0, 32'h500, 1'b1, 1'b0, 1'b1, 0, 0);
    n_checks++; if (ob_addr.size() !== 4) $display("FAIL rmid_again_words got %0d want 4", ob_addr.size()); else n_pass++;
    n_checks++; if (wr_num.size() !== 5) $display("FAIL rmid_again_writes got %0d want 5", wr_num.size()); else n_pass++;
    if (ob_addr.size() == 4 && wr_num.size() == 5) begin
      n_checks++; if (ob_addr[0] !== 32'h500 || ob_addr[3] !== 32'h50C)
        $display("FAIL rmid_again_addr got %h..%h want 500..50c", ob_addr[0], ob_addr[3]); else n_pass++;
      n_checks++; if (wr_num[0] !== 5'd4 || wr_data[0] !== ob_rdata[0])
        $display("FAIL rmid_again_wr0 got r%0d=%h want r4=%h", wr_num[0], wr_data[0], ob_rdata[0]); else n_pass++;
      n_checks++; if (wr_num[4] !== 5'd0 || wr_data[4] !== 32'h510)
        $display("FAIL rmid_again_wb got r%0d=%h want r0=510", wr_num[4], wr_data[4]); else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      logic ld, u, p, w;
      logic [15:0] lst;
      logic [3:0] br;
      logic [31:0] base;
      logic [4:0] ew_num[$];
      logic [31:0] ew_data[$];
      ld = 1'($urandom); u = 1'($urandom); p = 1'($urandom); w = 1'($urandom);
      br = 4'($urandom); base = $urandom;
      case (it % 5)
        0:       lst = 16'h0;
        1:       lst = 16'hFFFF;
        2:       lst = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: lst = 16'($urandom);
      endcase
      run_xfer(ld, lst, br, base, u, p, w, 0, 2);
      build_model(ld, lst, br, base, u, p, w);
      n_checks++; if (timed_out) $display("FAIL rnd%0d_done got none want pulse", it); else n_pass++;
      n_checks++; if (ob_addr.size() !== exp_addr.size())
        $display("FAIL rnd%0d_words got %0d want %0d", it, ob_addr.size(), exp_addr.size()); else n_pass++;
      n_checks++; if (unstable_cnt !== 0) $display("FAIL rnd%0d_stable got %0d want 0", it, unstable_cnt); else n_pass++;
      for (int k = 0; k < exp_addr.size() && k < ob_addr.size(); k++) begin
        n_checks++;
        if (ob_addr[k] !== exp_addr[k] || ob_we[k] !== !ld || ob_rnum[k] !== 5'(exp_reg[k]))
          $display("FAIL rnd%0d_word%0d got %h/%b/r%0d want %h/%b/r%0d", it, k, ob_addr[k], ob_we[k],
                   ob_rnum[k], exp_addr[k], !ld, exp_reg[k]);
        else n_pass++;
        if (!ld) begin
          n_checks++;
          if (ob_wdata[k] !== rf_snap[exp_reg[k]])
            $display("FAIL rnd%0d_wdata%0d got %h want %h", it, k, ob_wdata[k], rf_snap[exp_reg[k]]);
          else n_pass++;
        end else begin
          ew_num.push_back(5'(exp_reg[k]));
          ew_data.push_back(ob_rdata[k]);
        end
      end
      if (exp_wb) begin
        ew_num.push_back({1'b0, br});
        ew_data.push_back(exp_final);
      end
      n_checks++; if (wr_num.size() !== ew_num.size())
        $display("FAIL rnd%0d_writes got %0d want %0d", it, wr_num.size(), ew_num.size()); else n_pass++;
      for (int k = 0; k < ew_num.size() && k < wr_num.size(); k++) begin
        n_checks++;
        if (wr_num[k] !== ew_num[k] || wr_data[k] !== ew_data[k])
          $display("FAIL rnd%0d_wr%0d got r%0d=%h want r%0d=%h", it, k, wr_num[k], wr_data[k],
                   ew_num[k], ew_data[k]);
        else n_pass++;
      end
      n_checks++;
      if (exp_addr.size() == 0) begin
        if (done_cyc !== 0 || req_cyc_cnt !== 0)
          $display("FAIL rnd%0d_empty got done@%0d req=%0d want done@0 req=0", it, done_cyc, req_cyc_cnt);
        else n_pass++;
      end else begin
        if (done_cyc !== last_ack_cyc + (exp_wb ? 2 : 1) || first_req_cyc !== 0)
          $display("FAIL rnd%0d_timing got req@%0d done@%0d want req@0 done@%0d", it, first_req_cyc,
                   done_cyc, last_ack_cyc + (exp_wb ? 2 : 1));
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldmia();
    test_stmdb_wb();
    test_ldmib_stall();
    test_empty();
    test_base_in_list();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/block_xfer_seq.md
# block_xfer_seq

Load/store-multiple sequencer that drives the 16-entry register file for ARM LDM/STM instructions. It walks a 16-bit register list in ascending order, issuing one register-file access and one memory word transfer per handshake, then optionally writes back the updated base register. The block sits between instruction decode and the register file/memory port, and owns the register-file write port while busy.

## Interface
- No parameters; register count is fixed at 16 and register number width at 5.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  begin a transfer; sampled only in IDLE
- is_load  in  1  1 = LDM, 0 = STM
- reg_list  in  16  bit i set = transfer r[i]
- base_reg  in  4  base register number
- base_addr  in  32  current base value
- up  in  1  U bit: 1 = increment, 0 = decrement
- pre  in  1  P bit: 1 = before, 0 = after
- wback  in  1  W bit: write back the base
- rf_read_num  out  5  register-file read select; this is the current register for STM
- rf_read_data  in  32  asynchronous read data from the register file
- rf_write_num  out  5  register-file write select
- rf_write_data  out  32  register-file write data
- rf_regwrite  out  1  register-file write enable
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr  out  32  word address
- mem_wdata  out  32  store data, equal to rf_read_data
- mem_ack  in  1  transfer completes in any cycle where mem_req && mem_ack
- mem_rdata  in  32  load data, valid with mem_ack
- busy  out  1  high in XFER and WB
- done  out  1  one-cycle pulse in DONE

## Operation
- States: IDLE, XFER, WB, DONE.
- IDLE: on start, latch all inputs and compute n = popcount(reg_list).
  - n = 0: go to DONE.
  - n > 0: go to XFER.
- Start address, computed modulo 2^32:
  - IA: base.
  - IB: base+4.
  - DA: base−4n+4.
  - DB: base−4n.
- Final base: base+4n if up, else base−4n.
- Width rules: n is 5 bits; 4n is 7 bits, zero-extended to 32.
- XFER: current register is the lowest set bit of the remaining list.
  - mem_req=1; mem_we=!is_load; mem_addr=current address.
  - rf_read_num = current register.
  - On ack (load): rf_regwrite=1 in the same cycle, with rf_write_num=current register and rf_write_data=mem_rdata.
  - On ack (any): clear the bit and add 4 to the address.
  - After the last ack: go to WB if wback and not (is_load and base_reg in list); otherwise go to DONE.
- WB: one cycle with rf_regwrite=1, rf_write_num=base_reg, rf_write_data=final base; then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- start outside IDLE is ignored.
- Register list order is always ascending: the lowest register uses the lowest address.

## Timing
- Reset values: state=IDLE. All outputs 0, including rf_read_num, rf_write_num and mem_addr.
- Start-to-request latency: start sampled at edge k → mem_req high from cycle k+1.
- Request stability: mem_addr, mem_we and rf_read_num are held stable while mem_req && !mem_ack.
- Back-to-back acks: one word per cycle.
- done timing:
  - done is high one cycle after the last ack when there is no WB.
  - done is high two cycles after the last ack when WB occurs.
  - Empty list: done in cycle k+1; mem_req is never asserted.
- Reset mid-operation: the next edge returns to IDLE with outputs 0.
  - No further register-file writes occur.
  - A mem_ack arriving in the reset cycle is ignored.
- rf_regwrite is never asserted outside XFER-ack cycles and WB.

## Structure
- Shared package arm_rf_pkg holds:
  - state enum.
  - REG_NUM_W=5, NUM_REGS=16.
  - constant WORD_BYTES=4.
  - addressing-mode encoding {pre,up}.
- One sub-module, reg_list_scan (combinational): 16-bit list → lowest set index (4 bits), any_set, popcount (5 bits).

## Test plan
- LDMIA base=0x100, list=0x0005, wback=0, acks in consecutive cycles → mem_addr 0x100 then 0x104; r0 and r2 written with mem_rdata; no base write; done one cycle after the second ack.
- STMDB base_reg=13, base=0x200, list=0x4006, wback=1 → addresses 0x1F4, 0x1F8, 0x1FC with data r1, r2, r14; WB writes r13=0x1F4; then done.
- LDMIB base=0x40, list=0x0001, mem_ack withheld 3 cycles → mem_addr=0x44 held stable; no rf write until ack; write r0 on the ack cycle.
- start with list=0x0000 → done at k+1; mem_req and rf_regwrite stay 0.
- LDMIA base_reg=3, list=0x0008, wback=1, mem_rdata=0xDEAD → r3=0xDEAD; no WB cycle.
- reset asserted after the first of 4 acks → outputs 0 at the next edge; no more writes; a new start then runs a full transfer correctly.
